sram_arbiter: RTL and testbench

Sequencer and arbiter for the single external 8-bit asynchronous SRAM. It shares the SRAM between three requesters: the ROM/init loader, the core memory port, and an auxiliary port for DMA or a tape buffer. It generates all SRAM control timing (address setup, write pulse, data hold, read sampling) and returns data and acknowledges through a req/ack handshake. It sits between the machine core / controller and the top-level tristate pad logic.

---
 rtl/sram_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external 8-bit asynchronous SRAM between the
// loader (write-only), port A and port B. Generates address setup, write
// pulse, data hold and read sampling, and completes each access with a
// one-cycle ack pulse.
//
// Handshake (all three requesters): a requester raises req (iniW/aReq/bReq)
// and holds it, together with address, data and direction, until it sees
// its ack pulse. The ack is a single-cycle completion strobe. In the ack
// cycle that requester's req is ignored, so a req that is still high only
// because the requester has not yet reacted cannot start a duplicate access.
// Read data on aQ/bQ is valid from the ack cycle until the next read
// completes on that port.
module sram_arbiter #(
  parameter int AW        = 21,
  parameter int WE_CYCLES = 2,
  parameter int BMAX      = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          init,
  // loader port
  input  logic          iniW,
  input  logic [AW-1:0] iniA,
  input  logic [7:0]    iniD,
  output logic          iniAck,
  // port A
  input  logic          aReq,
  input  logic          aWr,
  input  logic [AW-1:0] aA,
  input  logic [7:0]    aD,
  output logic [7:0]    aQ,
  output logic          aAck,
  // port B
  input  logic          bReq,
  input  logic          bWr,
  input  logic [AW-1:0] bA,
  input  logic [7:0]    bD,
  output logic [7:0]    bQ,
  output logic          bAck,
  // SRAM pad side
  output logic          sramWe,
  output logic [AW-1:0] sramA,
  output logic [7:0]    sramDQo,
  output logic          sramDQe,
  input  logic [7:0]    sramDQi,
  // debug: current FSM state (0 = IDLE, 1 = RD1, 2 = RD2, 3 = WSET,
  // 4 = WPUL, 5 = WHLD)
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_WSET = 3'd3,
    S_WPUL = 3'd4,
    S_WHLD = 3'd5
  } state_t;

  localparam logic [1:0] OWN_INI = 2'd0;
  localparam logic [1:0] OWN_A   = 2'd1;
  localparam logic [1:0] OWN_B   = 2'd2;

  // Pulse-length counter holds the remaining WPUL cycles after the current one.
  localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  // Starvation counter saturates at BMAX.
  localparam int SW = $clog2(BMAX + 1);

  // Control / datapath registers
  state_t          state_q,   state_d;
  logic [1:0]      owner_q,   owner_d;
  logic            wr_q,      wr_d;
  logic [AW-1:0]   addr_q,    addr_d;     // latched address, drives sramA
  logic [7:0]      dqo_q,     dqo_d;      // latched write data, drives sramDQo
  logic [CW-1:0]   we_cnt_q,  we_cnt_d;
  logic [SW-1:0]   starve_q,  starve_d;

  // Registered outputs
  logic            we_q,      we_d;
  logic            dqe_q,     dqe_d;
  logic            ini_ack_q, ini_ack_d;
  logic            a_ack_q,   a_ack_d;
  logic            b_ack_q,   b_ack_d;
  logic [7:0]      aq_q,      aq_d;
  logic [7:0]      bq_q,      bq_d;

  // Arbitration terms
  logic            ini_v, a_v, b_v;
  logic            b_forced;
  logic            grant_ini, grant_a, grant_b;

  // Requests masked by their own ack, then prioritised for the current phase.
  always_comb begin
    ini_v     = iniW & ~ini_ack_q;
    a_v       = aReq & ~a_ack_q;
    b_v       = bReq & ~b_ack_q;
    b_forced  = (starve_q >= SW'(BMAX));
    grant_ini = 1'b0;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    if (state_q == S_IDLE) begin
      if (!init) begin
        grant_ini = ini_v;
      end else begin
        grant_b = b_v & (b_forced | ~a_v);
        grant_a = a_v & ~grant_b;
      end
    end
  end

  // State register and all datapath/output flops; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_INI;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      dqo_q     <= '0;
      we_cnt_q  <= '0;
      starve_q  <= '0;
      we_q      <= 1'b1;
      dqe_q     <= 1'b0;
      ini_ack_q <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      aq_q      <= '0;
      bq_q      <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      dqo_q     <= dqo_d;
      we_cnt_q  <= we_cnt_d;
      starve_q  <= starve_d;
      we_q      <= we_d;
      dqe_q     <= dqe_d;
      ini_ack_q <= ini_ack_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      aq_q      <= aq_d;
      bq_q      <= bq_d;
    end
  end

  // Next-state logic: sequencing, grant latching and starvation tracking.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    dqo_d    = dqo_q;
    we_cnt_d = we_cnt_q;
    starve_d = starve_q;

    case (state_q)
      S_IDLE: begin
        if (grant_ini) begin
          owner_d = OWN_INI;
          wr_d    = 1'b1;         // the loader only ever writes
          addr_d  = iniA;
          dqo_d   = iniD;
          state_d = S_WSET;
        end else if (grant_a) begin
          owner_d = OWN_A;
          wr_d    = aWr;
          addr_d  = aA;
          dqo_d   = aD;
          state_d = aWr ? S_WSET : S_RD1;
        end else if (grant_b) begin
          owner_d = OWN_B;
          wr_d    = bWr;
          addr_d  = bA;
          dqo_d   = bD;
          state_d = bWr ? S_WSET : S_RD1;
        end
      end
      S_RD1: state_d = S_RD2;
      S_RD2: state_d = S_IDLE;
      S_WSET: begin
        we_cnt_d = CW'(WE_CYCLES - 1);
        state_d  = S_WPUL;
      end
      S_WPUL: begin
        if (we_cnt_q == '0) begin
          state_d = S_WHLD;
        end else begin
          we_cnt_d = we_cnt_q - CW'(1);
        end
      end
      S_WHLD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // B waiting is only counted while bReq is actually up.
    if (!bReq || grant_b) begin
      starve_d = '0;
    end else if (grant_a && (starve_q < SW'(BMAX))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Output logic: pad controls follow the next state so they come out of
  // flops; acks and read data follow the state being left.
  always_comb begin
    we_d      = (state_d != S_WPUL);
    dqe_d     = (state_d == S_WSET) || (state_d == S_WPUL) || (state_d == S_WHLD);
    ini_ack_d = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    aq_d      = aq_q;
    bq_d      = bq_q;
    if ((state_q == S_RD2) || (state_q == S_WHLD)) begin
      ini_ack_d = (owner_q == OWN_INI);
      a_ack_d   = (owner_q == OWN_A);
      b_ack_d   = (owner_q == OWN_B);
    end
    if (state_q == S_RD2) begin
      if (owner_q == OWN_A) aq_d = sramDQi;
      if (owner_q == OWN_B) bq_d = sramDQi;
    end
  end

  assign iniAck    = ini_ack_q;
  assign aAck      = a_ack_q;
  assign bAck      = b_ack_q;
  assign aQ        = aq_q;
  assign bQ        = bq_q;
  assign sramWe    = we_q;
  assign sramDQe   = dqe_q;
  assign sramA     = addr_q;
  assign sramDQo   = dqo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: random requesters on all three ports, an SRAM
// model on the pad side, and a transaction-level reference that predicts
// acks, pad timing and read data from grant time and access type.
module tb_sram_arbiter;

  localparam int AW        = 21;
  localparam int WE_CYCLES = 2;
  localparam int BMAX      = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, init;
  logic          iniW;  logic [AW-1:0] iniA; logic [7:0] iniD; logic iniAck;
  logic          aReq, aWr; logic [AW-1:0] aA; logic [7:0] aD, aQ; logic aAck;
  logic          bReq, bWr; logic [AW-1:0] bA; logic [7:0] bD, bQ; logic bAck;
  logic          sramWe, sramDQe;
  logic [AW-1:0] sramA;
  logic [7:0]    sramDQo, sramDQi;
  logic [2:0]    dbg_state;

  sram_arbiter #(.AW(AW), .WE_CYCLES(WE_CYCLES), .BMAX(BMAX)) dut (
    .clock(clock), .reset(reset), .init(init),
    .iniW(iniW), .iniA(iniA), .iniD(iniD), .iniAck(iniAck),
    .aReq(aReq), .aWr(aWr), .aA(aA), .aD(aD), .aQ(aQ), .aAck(aAck),
    .bReq(bReq), .bWr(bWr), .bA(bA), .bD(bD), .bQ(bQ), .bAck(bAck),
    .sramWe(sramWe), .sramA(sramA), .sramDQo(sramDQo), .sramDQe(sramDQe),
    .sramDQi(sramDQi), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- SRAM environment and reference memory ----------------
  logic [7:0] sram_mem [logic [AW-1:0]];
  logic [7:0] ref_mem  [logic [AW-1:0]];

  function automatic logic [7:0] fill(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  function automatic logic [7:0] env_rd(input logic [AW-1:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return fill(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return fill(a);
  endfunction

  // ---------------- requesters (0 = loader, 1 = A, 2 = B) ----------------
  logic          pend  [3];
  logic          rq_wr [3];
  logic [AW-1:0] rq_a  [3];
  logic [7:0]    rq_d  [3];
  int            prob  [3];     // percent chance per cycle of a new request
  int            ack_cnt  [3];
  int            last_ack [3];
  logic          rst_req, init_v;

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 31));
    if ($urandom_range(0, 1) == 1) a[20:16] = 5'h1F;
    return a;
  endfunction

  task automatic issue(input int p, input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
    pend[p]  = 1'b1;
    rq_wr[p] = wr;
    rq_a[p]  = a;
    rq_d[p]  = d;
  endtask

  // ---------------- reference model ----------------
  logic          m_busy, m_wr;
  int            m_owner, m_start, m_cnt;
  logic [AW-1:0] m_addr, exp_sa;
  logic [7:0]    m_data, exp_dqo;
  logic [7:0]    exp_q [3];
  logic [2:0]    exp_ack;

  task automatic model_reset();
    m_busy = 1'b0; m_wr = 1'b0; m_owner = 0; m_start = 0; m_cnt = 0;
    m_addr = '0; m_data = '0; exp_sa = '0; exp_dqo = '0;
    exp_q[0] = '0; exp_q[1] = '0; exp_q[2] = '0;
    exp_ack = '0;
  endtask

  // Advance the model by one clock using the inputs applied in cycle cyc.
  task automatic model_step();
    logic ie, ae, be, g_ini, g_a, g_b;
    logic [2:0] nack;
    nack = '0; g_ini = 1'b0; g_a = 1'b0; g_b = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      // Last busy cycle: RD2 for a read, the hold cycle for a write.
      if (cyc == m_start + (m_wr ? 2 + WE_CYCLES : 2)) begin
        m_busy = 1'b0;
        nack[m_owner] = 1'b1;
        if (!m_wr) exp_q[m_owner] = ref_rd(m_addr);
      end
    end else begin
      ie = iniW && !exp_ack[0];
      ae = aReq && !exp_ack[1];
      be = bReq && !exp_ack[2];
      if (!init) g_ini = ie;
      else if (ae && !(be && m_cnt >= BMAX)) g_a = 1'b1;
      else if (be) g_b = 1'b1;
      if (g_ini || g_a || g_b) begin
        m_busy  = 1'b1;
        m_start = cyc;
        m_owner = g_ini ? 0 : (g_a ? 1 : 2);
        m_wr    = g_ini ? 1'b1 : (g_a ? aWr : bWr);
        m_addr  = g_ini ? iniA : (g_a ? aA : bA);
        m_data  = g_ini ? iniD : (g_a ? aD : bD);
        exp_sa  = m_addr;
        exp_dqo = m_data;
      end
    end
    if (!bReq || g_b) m_cnt = 0;
    else if (g_a) m_cnt++;
    exp_ack = nack;
  endtask

  // ---------------- one cycle: check, drive, predict ----------------
  task automatic tick();
    int off;
    logic we_e, dqe_e;
    logic [2:0] acks;
    @(negedge clock);
    we_e = 1'b1; dqe_e = 1'b0;
    if (m_busy && m_wr) begin
      off   = cyc - m_start;
      dqe_e = (off >= 1) && (off <= 2 + WE_CYCLES);
      we_e  = !((off >= 2) && (off <= 1 + WE_CYCLES));
      if (off == 2) ref_mem[m_addr] = m_data;
    end
    check("iniAck",  iniAck,  exp_ack[0]);
    check("aAck",    aAck,    exp_ack[1]);
    check("bAck",    bAck,    exp_ack[2]);
    check("sramWe",  sramWe,  we_e);
    check("sramDQe", sramDQe, dqe_e);
    check("sramA",   sramA,   exp_sa);
    if (dqe_e) check("sramDQo", sramDQo, exp_dqo);
    check("aQ", aQ, exp_q[1]);
    check("bQ", bQ, exp_q[2]);

    // SRAM captures data while the write strobe is low.
    if (sramWe == 1'b0) sram_mem[sramA] = sramDQo;

    acks = {bAck, aAck, iniAck};
    for (int p = 0; p < 3; p++) begin
      if (acks[p]) begin
        pend[p] = 1'b0;
        ack_cnt[p]++;
        last_ack[p] = cyc;
      end
      if (!pend[p] && ($urandom_range(1, 100) <= prob[p])) begin
        issue(p, (p == 0) ? 1'b1 : 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom_range(0, 255)));
      end
    end
    reset = rst_req;
    init  = init_v;
    iniW  = pend[0]; iniA = rq_a[0]; iniD = rq_d[0];
    aReq  = pend[1]; aWr  = rq_wr[1]; aA = rq_a[1]; aD = rq_d[1];
    bReq  = pend[2]; bWr  = rq_wr[2]; bA = rq_a[2]; bD = rq_d[2];
    sramDQi = env_rd(sramA);

    model_step();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  int t0, acks_before;

  initial begin
    reset = 1'b1; init = 1'b0;
    iniW = 1'b0; iniA = '0; iniD = '0;
    aReq = 1'b0; aWr = 1'b0; aA = '0; aD = '0;
    bReq = 1'b0; bWr = 1'b0; bA = '0; bD = '0;
    sramDQi = '0;
    rst_req = 1'b1; init_v = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pend[p] = 1'b0; rq_wr[p] = 1'b0; rq_a[p] = '0; rq_d[p] = '0;
      prob[p] = 0; ack_cnt[p] = 0; last_ack[p] = -1;
    end
    model_reset();
    repeat (2) @(posedge clock);

    // Reset state.
    tick();
    check("rst_state", dbg_state, 3'd0);
    rst_req = 1'b0;
    tick();

    // A write 0x00123 <- 0x5A: ack five cycles after the request is seen.
    init_v = 1'b1;
    issue(1, 1'b1, 21'h00123, 8'h5A);
    t0 = cyc;
    run(8);
    check("wr_ack_lat", last_ack[1] - t0, 5);
    check("wr_mem", env_rd(21'h00123), 8'h5A);

    // A read of 0x04000 returns 0xC3 three cycles after the request.
    sram_mem[21'h04000] = 8'hC3;
    ref_mem[21'h04000]  = 8'hC3;
    issue(1, 1'b0, 21'h04000, 8'h00);
    t0 = cyc;
    run(6);
    check("rd_ack_lat", last_ack[1] - t0, 3);
    check("rd_q", aQ, 8'hC3);

    // Loader phase: loader, A and B all asking; only the loader is served.
    init_v = 1'b0;
    acks_before = ack_cnt[1] + ack_cnt[2];
    prob[0] = 100;
    issue(1, 1'b0, 21'h00010, 8'h00);
    issue(2, 1'b1, 21'h00011, 8'h77);
    run(40);
    check("init0_ab_acks", ack_cnt[1] + ack_cnt[2], acks_before);
    prob[0] = 0;
    run(10);
    init_v = 1'b1;
    run(12);
    check("init1_ab_acks", ack_cnt[1] + ack_cnt[2], acks_before + 2);

    // Both run ports asking continuously.
    prob[1] = 100; prob[2] = 100;
    run(80);
    prob[1] = 0; prob[2] = 0;
    run(20);

    // Reset in the middle of the write pulse drops the access.
    issue(1, 1'b1, 21'h00044, 8'hA5);
    t0 = cyc;
    run(2);
    rst_req = 1'b1;
    pend[1] = 1'b0;
    tick();
    rst_req = 1'b0;
    acks_before = ack_cnt[1];
    tick();
    check("rst_mid_state", dbg_state, 3'd0);
    run(8);
    check("rst_mid_noack", ack_cnt[1], acks_before);

    // Run phase starts while a loader write is in flight.
    init_v = 1'b0;
    issue(0, 1'b1, 21'h00050, 8'h3C);
    t0 = cyc;
    run(2);
    init_v = 1'b1;
    issue(1, 1'b0, 21'h00050, 8'h00);
    run(12);
    check("toggle_ini_ack", last_ack[0] - t0, 5);
    check("toggle_a_ack", last_ack[1] - t0, 8);
    check("toggle_a_q", aQ, 8'h3C);

    // Random mix of phases, request rates, init flips and resets.
    for (int blk = 0; blk < 12; blk++) begin
      init_v = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 3; p++) prob[p] = $urandom_range(0, 60);
      for (int i = 0; i < 200; i++) begin
        rst_req = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 49) == 0) init_v = ~init_v;
        tick();
      end
    end
    rst_req = 1'b0;
    for (int p = 0; p < 3; p++) prob[p] = 0;
    run(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
